// File: rtl/mp_alu_seq_if.sv
// Bundle between issue logic, the word-serial sequencer and the shared N-bit ALU.
// master = environment (issue side plus the external ALU), slave = sequencer.
interface mp_alu_seq_if #(
  parameter int N  = 32,
  parameter int W  = 4,
  parameter int LW = $clog2(W + 1)
);
  logic           start;
  logic [1:0]     op;
  logic [LW-1:0]  len;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [1:0]     alu_m;
  logic           alu_cin;
  logic [N-1:0]   alu_r;
  logic           alu_cout;
  logic           busy;
  logic           done;
  logic [N*W-1:0] r;
  logic           v;
  logic           c;
  logic           n;
  logic           z;

  modport master (
    output start, op, len, a, b, alu_r, alu_cout,
    input  alu_a, alu_b, alu_m, alu_cin, busy, done, r, v, c, n, z
  );

  modport slave (
    input  start, op, len, a, b, alu_r, alu_cout,
    output alu_a, alu_b, alu_m, alu_cin, busy, done, r, v, c, n, z
  );
endinterface

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: runs an op of up to W words through one N-bit ALU,
// LS word first, chaining carry and accumulating the result and whole-operand flags.
module mp_alu_seq #(
  parameter int N  = 32,
  parameter int W  = 4,
  parameter int LW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  mp_alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  idx_q, len_q, sel, len_eff;
  logic [1:0]     op_q;
  logic [N*W-1:0] a_q, b_q;
  logic [N-1:0]   r_q [W];
  logic [N-1:0]   cur_a, cur_b;
  logic           carry_q, zacc_q, done_q;
  logic           v_q, c_q, n_q, z_q;
  logic           run, accept, last, res_zero;

  assign run      = (state_q == RUN);
  assign accept   = bus.start && !run;
  assign last     = (idx_q == len_q - LW'(1));
  assign res_zero = (bus.alu_r == '0);
  assign len_eff  = (bus.len == '0 || bus.len > LW'(W)) ? LW'(W) : bus.len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Outside RUN the ALU sees word 0 so its inputs stay deterministic.
  always_comb begin
    sel          = run ? idx_q : '0;
    cur_a        = a_q[int'(sel)*N +: N];
    cur_b        = b_q[int'(sel)*N +: N];
    bus.alu_a    = cur_a;
    bus.alu_b    = cur_b;
    bus.alu_m    = op_q;
    if (op_q[1])                  bus.alu_cin = 1'b0;
    else if (!run || idx_q == '0) bus.alu_cin = op_q[0];
    else                          bus.alu_cin = carry_q;
    bus.busy     = run;
    bus.done     = done_q;
    bus.v        = v_q;
    bus.c        = c_q;
    bus.n        = n_q;
    bus.z        = z_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q   <= bus.op;
        len_q  <= len_eff;
        a_q    <= bus.a;
        b_q    <= bus.b;
        idx_q  <= '0;
        zacc_q <= 1'b1;
      end else if (run) begin
        carry_q <= bus.alu_cout;
        zacc_q  <= zacc_q & res_zero;
        idx_q   <= idx_q + LW'(1);
        // Sign bits of the top active word decide overflow; cur_a/cur_b are that word here.
        if (last) begin
          v_q    <= ~op_q[1] & (cur_a[N-1] ^ bus.alu_r[N-1])
                    & ~(cur_a[N-1] ^ cur_b[N-1] ^ op_q[0]);
          c_q    <= ~op_q[1] & bus.alu_cout;
          n_q    <= bus.alu_r[N-1];
          z_q    <= zacc_q & res_zero;
          done_q <= 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_q[gi] <= '0;
        else if (accept)                           r_q[gi] <= '0;
        else if (run && idx_q == LW'(gi))          r_q[gi] <= bus.alu_r;
      end
      assign bus.r[gi*N +: N] = r_q[gi];
    end
  endgenerate
endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: behavioural ALU, whole-operand reference model and
// a done-driven scoreboard; scenario tasks add their own inline checks.
module tb_mp_alu_seq;
  localparam int N  = 32;
  localparam int W  = 4;
  localparam int LW = $clog2(W + 1);
  localparam int TW = N * W;

  typedef struct {
    logic [TW-1:0] r;
    logic          v, c, n, z;
    int            done_cyc;
    int            id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mp_alu_seq_if #(.N(N), .W(W), .LW(LW)) bus ();

  mp_alu_seq #(.N(N), .W(W), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External N-bit ALU
  always_comb begin
    bus.alu_r    = '0;
    bus.alu_cout = 1'b0;
    case (bus.alu_m)
      2'b00:   {bus.alu_cout, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + (N+1)'(bus.alu_cin);
      2'b01:   {bus.alu_cout, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + (N+1)'(bus.alu_cin);
      2'b10:   bus.alu_r = bus.alu_a & bus.alu_b;
      default: bus.alu_r = bus.alu_a | bus.alu_b;
    endcase
  end

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   txn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff_len(input int l);
    return (l == 0 || l > W) ? W : l;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input int l,
                                 input logic [TW-1:0] a, input logic [TW-1:0] b);
    exp_t          e;
    logic [TW-1:0] mask, aa, bb;
    logic [TW:0]   s;
    logic          at, bt, rt;
    int            le = eff_len(l);
    for (int i = 0; i < TW; i++) mask[i] = (i < le * N);
    aa = a & mask;
    bb = b & mask;
    case (op)
      2'd0:    s = {1'b0, aa} + {1'b0, bb};
      2'd1:    s = {1'b0, aa} + {1'b0, (~bb) & mask} + 1;
      2'd2:    s = {1'b0, aa & bb};
      default: s = {1'b0, aa | bb};
    endcase
    e.r = s[TW-1:0] & mask;
    at  = aa[le*N-1];
    bt  = bb[le*N-1];
    rt  = e.r[le*N-1];
    e.c = ~op[1] & s[le*N];
    e.v = ~op[1] & (at ^ rt) & ~(at ^ bt ^ op[0]);
    e.n = rt;
    e.z = (e.r == '0);
    e.done_cyc = 0;
    e.id = 0;
    return e;
  endfunction

  // Caller is between edges; start is sampled at the next rising edge.
  task automatic issue(input logic [1:0] op, input int l,
                       input logic [TW-1:0] a, input logic [TW-1:0] b);
    exp_t e;
    e = model(op, l, a, b);
    e.done_cyc = cyc + 1 + eff_len(l);
    e.id = txn;
    txn++;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.len   = LW'(l);
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.r !== mon_e.r) begin
          miscompares++;
          $display("FAIL result id=%0d got %h want %h", mon_e.id, bus.r, mon_e.r);
        end
        vectors++;
        if ({bus.v, bus.c, bus.n, bus.z} !== {mon_e.v, mon_e.c, mon_e.n, mon_e.z}) begin
          miscompares++;
          $display("FAIL flags id=%0d got vcnz=%b%b%b%b want %b%b%b%b", mon_e.id,
                   bus.v, bus.c, bus.n, bus.z, mon_e.v, mon_e.c, mon_e.n, mon_e.z);
        end
        vectors++;
        if (cyc != mon_e.done_cyc) begin
          miscompares++;
          $display("FAIL latency id=%0d got cyc %0d want cyc %0d", mon_e.id, cyc, mon_e.done_cyc);
        end
        $display("txn %0d: r=%h vcnz=%b%b%b%b at cyc %0d", mon_e.id, bus.r,
                 bus.v, bus.c, bus.n, bus.z, cyc);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done});
    end
    vectors++;
    if (bus.r !== '0 || {bus.v, bus.c, bus.n, bus.z} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_result got r=%h vcnz=%b%b%b%b want 0", bus.r, bus.v, bus.c, bus.n, bus.z);
    end
    vectors++;
    if (bus.alu_a !== '0 || bus.alu_b !== '0) begin
      miscompares++;
      $display("FAIL reset_alu_word got %h/%h want 0/0", bus.alu_a, bus.alu_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_ripple();
    @(negedge clk);
    issue(2'd0, 4, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1);
    vectors++;
    if ({bus.busy, bus.alu_a, bus.alu_cin} !== {1'b1, 32'hFFFFFFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL ripple_first_word got busy=%b a=%h cin=%b want 1 ffffffff 0",
               bus.busy, bus.alu_a, bus.alu_cin);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.alu_a, bus.alu_cin} !== {32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL ripple_carry_chain got a=%h cin=%b want 00000000 1", bus.alu_a, bus.alu_cin);
    end
    wait_drain();
  endtask

  task automatic test_sub_equal();
    @(negedge clk);
    issue(2'd1, 2, {32'hAAAA5555, 32'h00000001, 64'h12345678_9ABCDEF0},
                   {32'h11112222, 32'h00000003, 64'h12345678_9ABCDEF0});
    wait_drain();
  endtask

  task automatic test_len_bounds();
    @(negedge clk);
    issue(2'd0, 1, {96'h0000AAAA_00000000_00000001, 32'h7FFFFFFF}, 128'h1);
    wait_drain();
    @(negedge clk);
    issue(2'd0, 0, 128'h7FFFFFFF, 128'h1);
    wait_drain();
    @(negedge clk);
    issue(2'd1, 6, 128'h5, 128'h3);
    wait_drain();
    @(negedge clk);
    issue(2'd0, 4, {32'h7FFFFFFF, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF}, 128'h1);
    wait_drain();
  endtask

  task automatic test_sub_neg_and();
    @(negedge clk);
    issue(2'd1, 4, 128'h0, 128'h1);
    wait_drain();
    @(negedge clk);
    issue(2'd2, 4, {4{32'hF0F0F0F0}}, {4{32'h0F0F0F0F}});
    wait_drain();
    @(negedge clk);
    issue(2'd3, 3, {4{32'h12340000}}, {4{32'h00005678}});
    wait_drain();
  endtask

  task automatic test_random();
    logic [TW-1:0] ra, rb;
    for (int k = 0; k < 8; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 7), ra, rb);
      wait_drain();
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    issue(2'd0, 4, {4{32'h89ABCDEF}}, {4{32'h76543211}});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ignore_busy got %b want 1", bus.busy);
      end
      bus.start = 1'b1;
      bus.op    = 2'd3;
      bus.len   = LW'(1);
      bus.a     = '1;
      bus.b     = '1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(2'd1, 3, {4{32'h00000010}}, {4{32'h00000020}});
    for (int i = 0; i < 50 && bus.done !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_done got %b want 1", bus.done);
    end
    issue(2'd0, 2, {4{32'h80000000}}, {4{32'h80000000}});
    vectors++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_accept got done,busy=%b want 01", {bus.done, bus.busy});
    end
    wait_drain();
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle got %b want 0", bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    issue(2'd1, 2, 128'h0, 128'h1);
    wait_drain();
    @(negedge clk);
    issue(2'd0, 4, {4{32'h11111111}}, {4{32'h22222222}});
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL midrun_busy_done got %b want 00", {bus.busy, bus.done});
    end
    vectors++;
    if (bus.r !== '0 || {bus.v, bus.c, bus.n, bus.z} !== 4'b0) begin
      miscompares++;
      $display("FAIL midrun_clear got r=%h vcnz=%b%b%b%b want 0", bus.r, bus.v, bus.c, bus.n, bus.z);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL midrun_no_done got %b want 0", bus.done);
      end
    end
    issue(2'd0, 4, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1);
    wait_drain();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.len   = '0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_add_ripple();
    test_sub_equal();
    test_len_bounds();
    test_sub_neg_and();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mp_alu_seq.md
Name: mp_alu_seq

Overview:
Multi-precision sequencer for the shared N-bit ALU and its flag logic. It accepts an operation on operands of up to W words, LEN words active. It drives the external N-bit ALU one word per cycle, least-significant word first, and chains carry/borrow between words. It accumulates the full-width result and produces whole-operand V/C/N/Z flags. It sits between the issue logic and the ALU so that wide arithmetic reuses the single N-bit datapath.

Parameters:
N, 32, ALU word width in bits.
W, 4, maximum number of words per operation (W >= 1).
LW, $clog2(W+1), width of the len port.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; accepted only when busy=0.
op  input  2  00 add, 01 sub, 10 and, 11 or; latched at accept.
len  input  LW  active word count, latched at accept; 0 or >W is treated as W.
a  input  N*W  operand A, latched at accept.
b  input  N*W  operand B, latched at accept.
alu_a  output  N  current word of latched A.
alu_b  output  N  current word of latched B.
alu_m  output  2  latched op, driven to the ALU.
alu_cin  output  1  carry-in for the current word.
alu_r  input  N  combinational ALU result for the current word.
alu_cout  input  1  combinational ALU carry-out for the current word.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when the result and flags become valid.
r  output  N*W  accumulated result.
v  output  1  signed overflow flag.
c  output  1  carry (add) / no-borrow (sub) flag.
n  output  1  negative flag.
z  output  1  zero flag.

Behaviour:
- States: IDLE, RUN, DONE. Word index idx counts 0..LEN-1.
- Reset (async): state=IDLE, idx=0, busy=0, done=0, r=0, v=c=n=z=0. alu_* outputs are don't-care in IDLE but must be deterministic (drive word 0 of the latched regs).
- Accept: start=1 while state is IDLE or DONE, sampled at edge t.
  - Latch op, effective LEN, a, b.
  - Clear r to 0, zacc=1, idx=0, state=RUN.
  - start while busy is ignored, with no side effects.
- RUN, combinational outputs:
  - alu_a = a word idx; alu_b = b word idx; alu_m = op.
  - alu_cin = (idx==0) ? op[0] & ~op[1] : carry register.
  - For logic ops, alu_cin = 0.
- RUN, each edge:
  - r word idx <= alu_r.
  - carry <= alu_cout.
  - zacc <= zacc & (alu_r==0).
  - idx <= idx+1.
- Last word (idx==LEN-1), at that edge additionally:
  - v = ~op[1] & (a_top ^ r_top) & ~(a_top ^ b_top ^ op[0]), where a_top/b_top/r_top are bit N-1 of word LEN-1 (r_top taken from alu_r).
  - c = ~op[1] & alu_cout.
  - n = alu_r[N-1].
  - z = zacc & (alu_r==0).
  - done <= 1; state=DONE.
- Latency: done is high in the cycle after edge t+LEN, i.e. exactly LEN cycles after the accept edge.
- done is high for exactly one cycle. r/v/c/n/z hold until the next accept.
- Words >= LEN of r read 0.
- Back-to-back: start in the done cycle is accepted. done drops and state=RUN at the next edge.
- Reset mid-RUN: immediate return to reset values, with no done pulse.
- alu_r/alu_cout are ignored outside RUN.

Test Plan:
- N=32, W=4, len=4, add a=0x00000000_00000000_00000000_FFFFFFFF, b=1 -> carry ripples into word 1; r=0x...0001_00000000; v=0, c=0, n=0, z=0; done exactly 4 cycles after accept.
- sub, len=2, a=b=0x12345678_9ABCDEF0 -> r=0, z=1, c=1 (no borrow), v=0, n=0; words 2-3 of r = 0.
- add, len=1, a=0x7FFFFFFF, b=1 -> r=0x80000000, v=1, n=1, c=0; done 1 cycle after accept. len=0 with the same operands -> behaves as len=4, done after 4 cycles.
- sub, len=4, a=0, b=1 -> r=all ones, c=0, n=1, z=0, v=0. and, a=0xF0F0..., b=0x0F0F... -> r=0, z=1, c=0, v=0.
- start pulsed during RUN -> ignored, first result unchanged. start in the done cycle -> second op accepted, done pulses again after len cycles.
- reset asserted mid-RUN at idx=2 -> busy, done, r and flags cleared asynchronously. No done pulse, and the next start runs normally.
